// File: rtl/pe_group_conv.sv
// Parametrised 1-D convolution PE group: W_SIZE taps x O_SIZE outputs with
// multi-pass accumulation into per-output accumulators and a back-pressurable
// result stream. Loads arrive on three independent valid/ready streams.
module pe_group_conv #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned W_SIZE    = 4,
  parameter int unsigned O_SIZE    = 4,
  parameter int unsigned I_SIZE    = W_SIZE + O_SIZE - 1,
  parameter int unsigned PassWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PassWidth-1:0] cfg_passes,
  input  logic                 W_DataInValid,
  output logic                 W_DataInRdy,
  input  logic [DataWidth-1:0] W_DataIn,
  input  logic                 I_DataInValid,
  output logic                 I_DataInRdy,
  input  logic [DataWidth-1:0] I_DataIn,
  input  logic                 O_DataInValid,
  output logic                 O_DataInRdy,
  input  logic [DataWidth-1:0] O_DataIn,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut,
  output logic                 busy
);

  // I_SIZE is the largest count, so one counter width covers every stream.
  localparam int unsigned CntW = $clog2(I_SIZE + 1);
  localparam logic [CntW-1:0] WMax = CntW'(W_SIZE);
  localparam logic [CntW-1:0] IMax = CntW'(I_SIZE);
  localparam logic [CntW-1:0] OMax = CntW'(O_SIZE);
  localparam logic [CntW-1:0] One  = CntW'(1);

  typedef enum logic [1:0] {StInit, StLoad, StCompute, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        w_cnt_q, i_cnt_q, b_cnt_q, idx_q;
  logic [PassWidth-1:0]   pass_q, passes_q, pass_next;
  logic [DataWidth-1:0]   w_buf_q [W_SIZE];
  logic [DataWidth-1:0]   i_buf_q [I_SIZE];
  logic [DataWidth-1:0]   acc_q   [O_SIZE];
  logic [DataWidth-1:0]   mac;
  logic                   w_hs, i_hs, b_hs, out_hs;
  logic                   w_done, i_done, b_done, idx_last;

  // Handshake outputs decode only registered state and counters.
  always_comb begin
    W_DataInRdy    = (state_q == StLoad) && (w_cnt_q < WMax);
    I_DataInRdy    = (state_q == StLoad) && (i_cnt_q < IMax);
    O_DataInRdy    = (state_q == StLoad) && (pass_q == '0) && (b_cnt_q < OMax);
    O_DataOutValid = (state_q == StDrain);
    O_DataOut      = (state_q == StDrain) ? acc_q[0] : '0;
    busy           = (state_q == StCompute) || (state_q == StDrain);
    w_hs           = W_DataInValid && W_DataInRdy;
    i_hs           = I_DataInValid && I_DataInRdy;
    b_hs           = O_DataInValid && O_DataInRdy;
    out_hs         = O_DataOutValid && O_DataOutRdy;
    // "done" includes a handshake landing this cycle so COMPUTE starts right after it.
    w_done         = (w_cnt_q == WMax) || (w_hs && (w_cnt_q == WMax - One));
    i_done         = (i_cnt_q == IMax) || (i_hs && (i_cnt_q == IMax - One));
    b_done         = (pass_q != '0) || (b_cnt_q == OMax) || (b_hs && (b_cnt_q == OMax - One));
    idx_last       = (idx_q == OMax - One);
    pass_next      = pass_q + PassWidth'(1);
  end

  // Dot product of the taps with the current input window; wraps modulo 2^DataWidth,
  // which matches signed two's-complement truncation.
  always_comb begin
    mac = '0;
    for (int j = 0; j < int'(W_SIZE); j++) begin
      mac = mac + w_buf_q[j] * i_buf_q[j];
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:    state_d = StLoad;
      StLoad:    if (w_done && i_done && b_done) state_d = StCompute;
      StCompute: if (idx_last) state_d = (pass_next < passes_q) ? StLoad : StDrain;
      StDrain:   if (out_hs && idx_last) state_d = StLoad;
      default:   state_d = StInit;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StInit;
    else      state_q <= state_d;
  end

  // Datapath: buffer loads, pass bookkeeping, MAC into rotating accumulators, drain.
  // During COMPUTE the input window shifts and acc rotates so slot 0 is always
  // the output being worked on; after O_SIZE steps both return to natural order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cnt_q  <= '0;
      i_cnt_q  <= '0;
      b_cnt_q  <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
      passes_q <= PassWidth'(1);
      for (int j = 0; j < int'(W_SIZE); j++) w_buf_q[j] <= '0;
      for (int j = 0; j < int'(I_SIZE); j++) i_buf_q[j] <= '0;
      for (int j = 0; j < int'(O_SIZE); j++) acc_q[j]   <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (w_hs) begin
            for (int j = 0; j < int'(W_SIZE); j++)
              if (w_cnt_q == CntW'(j)) w_buf_q[j] <= W_DataIn;
            w_cnt_q <= w_cnt_q + One;
          end
          if (i_hs) begin
            for (int j = 0; j < int'(I_SIZE); j++)
              if (i_cnt_q == CntW'(j)) i_buf_q[j] <= I_DataIn;
            i_cnt_q <= i_cnt_q + One;
          end
          // Bias lands straight in its accumulator; only pass 0 accepts bias.
          if (b_hs) begin
            for (int j = 0; j < int'(O_SIZE); j++)
              if (b_cnt_q == CntW'(j)) acc_q[j] <= O_DataIn;
            b_cnt_q <= b_cnt_q + One;
          end
          if ((state_d == StCompute) && (pass_q == '0)) begin
            passes_q <= (cfg_passes == '0) ? PassWidth'(1) : cfg_passes;
          end
        end
        StCompute: begin
          for (int j = 0; j < int'(I_SIZE) - 1; j++) i_buf_q[j] <= i_buf_q[j+1];
          for (int j = 0; j < int'(O_SIZE) - 1; j++) acc_q[j] <= acc_q[j+1];
          acc_q[O_SIZE-1] <= acc_q[0] + mac;
          if (idx_last) begin
            idx_q   <= '0;
            pass_q  <= pass_next;
            w_cnt_q <= '0;
            i_cnt_q <= '0;
          end else begin
            idx_q <= idx_q + One;
          end
        end
        StDrain: begin
          if (out_hs) begin
            for (int j = 0; j < int'(O_SIZE) - 1; j++) acc_q[j] <= acc_q[j+1];
            acc_q[O_SIZE-1] <= acc_q[0];
            if (idx_last) begin
              idx_q   <= '0;
              pass_q  <= '0;
              b_cnt_q <= '0;
              w_cnt_q <= '0;
              i_cnt_q <= '0;
            end else begin
              idx_q <= idx_q + One;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_group_conv.sv
// Directed self-checking bench for pe_group_conv (default 4x4 geometry, 32-bit data).
module tb_pe_group_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_passes = 4'd1;
  logic        W_DataInValid = 1'b0, I_DataInValid = 1'b0, O_DataInValid = 1'b0;
  logic        W_DataInRdy, I_DataInRdy, O_DataInRdy;
  logic [31:0] W_DataIn = '0, I_DataIn = '0, O_DataIn = '0;
  logic        O_DataOutValid, busy;
  logic        O_DataOutRdy = 1'b0;
  logic [31:0] O_DataOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] w_vec [4];
  logic [31:0] i_vec [7];
  logic [31:0] b_vec [4];
  logic [31:0] got   [4];
  int          out_count, first_valid_n, hold_viol, bias_rdy_hi;
  logic        busy_start, busy_last;
  bit          pat [4];

  always #5 clk = ~clk;

  pe_group_conv dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_passes     (cfg_passes),
    .W_DataInValid  (W_DataInValid),
    .W_DataInRdy    (W_DataInRdy),
    .W_DataIn       (W_DataIn),
    .I_DataInValid  (I_DataInValid),
    .I_DataInRdy    (I_DataInRdy),
    .I_DataIn       (I_DataIn),
    .O_DataInValid  (O_DataInValid),
    .O_DataInRdy    (O_DataInRdy),
    .O_DataIn       (O_DataIn),
    .O_DataOutValid (O_DataOutValid),
    .O_DataOutRdy   (O_DataOutRdy),
    .O_DataOut      (O_DataOut),
    .busy           (busy)
  );

  // Stimulus: drive the load streams until every required word is accepted.
  task automatic load_group(input bit use_bias, input bit i_first);
    int wi = 0, ii = 0, bi = 0, budget = 0;
    bit hw, hi, hb;
    while (!(wi == 4 && ii == 7 && (bi == 4 || !use_bias)) && budget < 100) begin
      @(negedge clk);
      budget++;
      W_DataInValid = (wi < 4) && !(i_first && ii < 7);
      W_DataIn      = (wi < 4) ? w_vec[wi] : '0;
      I_DataInValid = (ii < 7);
      I_DataIn      = (ii < 7) ? i_vec[ii] : '0;
      O_DataInValid = use_bias && (bi < 4) && !(i_first && ii < 7);
      O_DataIn      = (bi < 4) ? b_vec[bi] : '0;
      if (!use_bias && O_DataInRdy) bias_rdy_hi++;
      hw = W_DataInValid && W_DataInRdy;
      hi = I_DataInValid && I_DataInRdy;
      hb = O_DataInValid && O_DataInRdy;
      @(posedge clk);
      if (hw) wi++;
      if (hi) ii++;
      if (hb) bi++;
    end
    if (budget >= 100) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got w=%0d i=%0d b=%0d words, need all", wi, ii, bi);
    end
    #1;
    W_DataInValid = 1'b0;
    I_DataInValid = 1'b0;
    O_DataInValid = 1'b0;
  endtask

  // Stimulus: collect four results, optionally with a 1,0,0,1 ready pattern.
  task automatic collect(input bit toggle);
    int n = 0;
    logic [31:0] prev_d = '0;
    bit prev_stall = 1'b0;
    out_count = 0;
    first_valid_n = -1;
    hold_viol = 0;
    busy_start = 1'b0;
    busy_last = 1'b0;
    while (out_count < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) busy_start = busy;
      O_DataOutRdy = toggle ? pat[(n - 1) % 4] : 1'b1;
      if (O_DataOutValid) begin
        if (first_valid_n < 0) first_valid_n = n;
        if (prev_stall && (O_DataOut !== prev_d)) hold_viol++;
        prev_d = O_DataOut;
        prev_stall = !O_DataOutRdy;
        if (O_DataOutRdy) begin
          got[out_count] = O_DataOut;
          if (out_count == 3) busy_last = busy;
          out_count++;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
    end
    #1 O_DataOutRdy = 1'b0;
  endtask

  task automatic set_scenario1();
    for (int j = 0; j < 4; j++) w_vec[j] = 32'(j + 1);
    for (int j = 0; j < 7; j++) i_vec[j] = 32'(j + 1);
    for (int j = 0; j < 4; j++) b_vec[j] = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    checks++; if (W_DataInRdy !== 1'b0) begin errors++; $display("FAIL rst_wrdy: got %b need 0", W_DataInRdy); end
    checks++; if (I_DataInRdy !== 1'b0) begin errors++; $display("FAIL rst_irdy: got %b need 0", I_DataInRdy); end
    checks++; if (O_DataInRdy !== 1'b0) begin errors++; $display("FAIL rst_brdy: got %b need 0", O_DataInRdy); end
    checks++; if (O_DataOutValid !== 1'b0) begin errors++; $display("FAIL rst_ovalid: got %b need 0", O_DataOutValid); end
    checks++; if (O_DataOut !== 32'd0) begin errors++; $display("FAIL rst_odata: got %h need 0", O_DataOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (W_DataInRdy !== 1'b0) begin errors++; $display("FAIL init_wrdy: got %b need 0", W_DataInRdy); end
    @(negedge clk);
    checks++; if (W_DataInRdy !== 1'b1) begin errors++; $display("FAIL load_wrdy: got %b need 1", W_DataInRdy); end
    checks++; if (O_DataInRdy !== 1'b1) begin errors++; $display("FAIL load_brdy: got %b need 1", O_DataInRdy); end
  endtask

  task automatic test_single_pass();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd30; exp_v[1] = 32'd40; exp_v[2] = 32'd50; exp_v[3] = 32'd60;
    cfg_passes = 4'd1;
    set_scenario1();
    load_group(1'b1, 1'b0);
    collect(1'b0);
    checks++; if (out_count !== 4) begin errors++; $display("FAIL sp_count: got %0d need 4", out_count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_v[k]) begin errors++; $display("FAIL sp_out%0d: got %0d need %0d", k, got[k], exp_v[k]); end
    end
    checks++; if (first_valid_n !== 5) begin errors++; $display("FAIL sp_latency: got %0d need 5", first_valid_n); end
    checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL sp_busy_compute: got %b need 1", busy_start); end
    checks++; if (busy_last !== 1'b1) begin errors++; $display("FAIL sp_busy_drain: got %b need 1", busy_last); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_busy_after: got %b need 0", busy); end
  endtask

  task automatic test_multipass();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd70; exp_v[1] = 32'd100; exp_v[2] = 32'd130; exp_v[3] = 32'd160;
    cfg_passes = 4'd2;
    set_scenario1();
    for (int j = 0; j < 4; j++) b_vec[j] = 32'(10 * (j + 1));
    load_group(1'b1, 1'b0);
    bias_rdy_hi = 0;
    load_group(1'b0, 1'b0);
    checks++; if (bias_rdy_hi !== 0) begin errors++; $display("FAIL mp_bias_rdy: got %0d high cycles need 0", bias_rdy_hi); end
    collect(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_v[k]) begin errors++; $display("FAIL mp_out%0d: got %0d need %0d", k, got[k], exp_v[k]); end
    end
    cfg_passes = 4'd1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd30; exp_v[1] = 32'd40; exp_v[2] = 32'd50; exp_v[3] = 32'd60;
    set_scenario1();
    load_group(1'b1, 1'b1);
    collect(1'b1);
    checks++; if (out_count !== 4) begin errors++; $display("FAIL bp_count: got %0d need 4", out_count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_v[k]) begin errors++; $display("FAIL bp_out%0d: got %0d need %0d", k, got[k], exp_v[k]); end
    end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes need 0", hold_viol); end
  endtask

  task automatic test_signed();
    for (int j = 0; j < 4; j++) w_vec[j] = '0;
    w_vec[0] = 32'hFFFF_FFFF;
    for (int j = 0; j < 7; j++) i_vec[j] = 32'd5;
    for (int j = 0; j < 4; j++) b_vec[j] = '0;
    load_group(1'b1, 1'b0);
    collect(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== 32'hFFFF_FFFB) begin errors++; $display("FAIL neg_out%0d: got %h need fffffffb", k, got[k]); end
    end
    w_vec[0] = 32'h7FFF_FFFF;
    for (int j = 0; j < 7; j++) i_vec[j] = '0;
    i_vec[0] = 32'd2;
    load_group(1'b1, 1'b0);
    collect(1'b0);
    checks++; if (got[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_out0: got %h need fffffffe", got[0]); end
    checks++; if (got[1] !== 32'h0) begin errors++; $display("FAIL wrap_out1: got %h need 0", got[1]); end
  endtask

  task automatic test_passes_cfg();
    cfg_passes = 4'd0;
    set_scenario1();
    load_group(1'b1, 1'b0);
    collect(1'b0);
    checks++; if (out_count !== 4) begin errors++; $display("FAIL p0_count: got %0d need 4", out_count); end
    checks++; if (got[0] !== 32'd30) begin errors++; $display("FAIL p0_out0: got %0d need 30", got[0]); end
    checks++; if (got[3] !== 32'd60) begin errors++; $display("FAIL p0_out3: got %0d need 60", got[3]); end
    cfg_passes = 4'd1;
    load_group(1'b1, 1'b0);
    cfg_passes = 4'd3;
    collect(1'b0);
    checks++; if (out_count !== 4) begin errors++; $display("FAIL pchg_count: got %0d need 4", out_count); end
    checks++; if (got[0] !== 32'd30) begin errors++; $display("FAIL pchg_out0: got %0d need 30", got[0]); end
    checks++; if (got[3] !== 32'd60) begin errors++; $display("FAIL pchg_out3: got %0d need 60", got[3]); end
    cfg_passes = 4'd1;
  endtask

  task automatic test_reset_mid();
    cfg_passes = 4'd2;
    set_scenario1();
    for (int j = 0; j < 4; j++) b_vec[j] = 32'(10 * (j + 1));
    load_group(1'b1, 1'b0);
    load_group(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b need 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b need 0", busy); end
    checks++; if (O_DataOutValid !== 1'b0) begin errors++; $display("FAIL rm_ovalid: got %b need 0", O_DataOutValid); end
    checks++; if (O_DataOut !== 32'd0) begin errors++; $display("FAIL rm_odata: got %h need 0", O_DataOut); end
    checks++; if ({W_DataInRdy, I_DataInRdy, O_DataInRdy} !== 3'b000) begin
      errors++; $display("FAIL rm_rdys: got %b need 000", {W_DataInRdy, I_DataInRdy, O_DataInRdy});
    end
    cfg_passes = 4'd1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (I_DataInRdy !== 1'b0) begin errors++; $display("FAIL rm_init_irdy: got %b need 0", I_DataInRdy); end
    set_scenario1();
    load_group(1'b1, 1'b0);
    collect(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== 32'(30 + 10 * k)) begin errors++; $display("FAIL rm_out%0d: got %0d need %0d", k, got[k], 30 + 10 * k); end
    end
    checks++; if (first_valid_n !== 5) begin errors++; $display("FAIL rm_latency: got %0d need 5", first_valid_n); end
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    test_reset();
    test_single_pass();
    test_multipass();
    test_back_to_back();
    test_signed();
    test_passes_cfg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
